// File: rtl/range_seq_pkg.sv
// ============================================================
// Module : range_seq_pkg
// Shared state encoding and default sizing for the range sequence transmitter.
// Rev    : 1.0
// ============================================================
`default_nettype none

package range_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GO     = 3'd1,
    ST_STREAM = 3'd2,
    ST_FINISH = 3'd3,
    ST_GAP    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/range_seq_tx_if.sv
// ============================================================
// Module : range_seq_tx_if
// Load/send handshake, range-protocol strobes and status of the transmitter.
// Rev    : 1.0
// ============================================================
`default_nettype none

interface range_seq_tx_if
  import range_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  localparam int LW = $clog2(DEPTH) + 1;

  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             send;
  logic             busy;
  logic             reject;
  logic             done;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] expected_range;
  logic [LW-1:0]    level;

  modport slave (
    input  wr_valid, wr_data, send,
    output wr_ready, busy, reject, done, go, finish, data_out, expected_range, level
  );

  modport master (
    output wr_valid, wr_data, send,
    input  wr_ready, busy, reject, done, go, finish, data_out, expected_range, level
  );

endinterface

`default_nettype wire

// File: rtl/range_seq_fifo.sv
// ============================================================
// Module : range_seq_fifo
// Sequence buffer: synchronous write, FSM-driven read pointer, level count, flush.
// Rev    : 1.0
// ============================================================
`default_nettype none

module range_seq_fifo
  import range_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  wire logic                       clock,
  input  wire logic                       reset,
  input  wire logic                       wr_en,
  input  wire logic [WIDTH-1:0]           wr_data,
  input  wire logic                       rd_en,
  input  wire logic                       clear,
  output logic      [WIDTH-1:0]           rd_data,
  output logic      [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Pointers are AW bits wide so they wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + (wr_en ? LW'(1) : LW'(0)) - (rd_en ? LW'(1) : LW'(0));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign level   = level_q;

endmodule

`default_nettype wire

// File: rtl/range_seq_tx.sv
// ============================================================
// Module : range_seq_tx
// Emits a buffered word sequence as go/data/finish and reports its max-min.
// Rev    : 1.0
// ============================================================
`default_nettype none

module range_seq_tx
  import range_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  wire logic       clock,
  input  wire logic       reset,
  range_seq_tx_if.slave   bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t           state_q, state_d;
  logic [LW-1:0]    n_q, n_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] range_q, range_d;
  logic             reject_q, reject_d;

  logic             wr_en;
  logic             rd_en;
  logic             clear;
  logic [WIDTH-1:0] word;
  logic [LW-1:0]    level;
  logic             go;
  logic             finish;
  logic             done;
  logic [WIDTH-1:0] data_out;

  assign bus.wr_ready = (state_q == ST_IDLE) && (level < LW'(DEPTH));
  assign wr_en        = bus.wr_valid && bus.wr_ready;

  range_seq_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .clear   (clear),
    .rd_data (word),
    .level   (level)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    min_d    = min_q;
    max_d    = max_q;
    range_d  = range_q;
    reject_d = 1'b0;
    rd_en    = 1'b0;
    clear    = 1'b0;
    go       = 1'b0;
    finish   = 1'b0;
    done     = 1'b0;
    data_out = '0;
    case (state_q)
      ST_IDLE: begin
        // level here is the pre-write value, so a same-cycle write does not count.
        if (bus.send) begin
          if (level >= LW'(2)) begin
            n_d     = level;
            state_d = ST_GO;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_GO: begin
        go       = 1'b1;
        data_out = word;
        rd_en    = 1'b1;
        min_d    = word;
        max_d    = word;
        idx_d    = LW'(1);
        state_d  = (n_q == LW'(2)) ? ST_FINISH : ST_STREAM;
      end
      ST_STREAM: begin
        data_out = word;
        rd_en    = 1'b1;
        if (word < min_q) min_d = word;
        if (word > max_q) max_d = word;
        idx_d = idx_q + LW'(1);
        if (idx_q == n_q - LW'(2)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        finish   = 1'b1;
        data_out = word;
        rd_en    = 1'b1;
        if (word < min_q) min_d = word;
        if (word > max_q) max_d = word;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        range_d = max_q - min_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        clear   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      idx_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      range_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      min_q    <= min_d;
      max_q    <= max_d;
      range_q  <= range_d;
      reject_q <= reject_d;
    end
  end

  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.reject         = reject_q;
  assign bus.done           = done;
  assign bus.go             = go;
  assign bus.finish         = finish;
  assign bus.data_out       = data_out;
  assign bus.expected_range = range_q;
  assign bus.level          = level;

endmodule

`default_nettype wire

// File: tb/tb_range_seq_tx.sv
// ============================================================
// Module : tb_range_seq_tx
// Directed bench for range_seq_tx with a behavioural range receiver alongside.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_range_seq_tx;

  logic clock;
  logic reset;
  int   passed;
  int   failed;
  int   total;

  range_seq_tx_if #(.WIDTH(8), .DEPTH(8)) bus ();

  range_seq_tx #(.WIDTH(8), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Receiver model: rebuilds the range from go/data/finish and flags protocol errors.
  logic       rx_active;
  logic [7:0] rx_min, rx_max, rx_range;
  logic       rx_err;

  always @(negedge clock) begin
    if (reset) begin
      rx_active <= 1'b0;
    end else begin
      if (bus.go && bus.finish) rx_err <= 1'b1;
      if (bus.go) begin
        if (rx_active) rx_err <= 1'b1;
        rx_active <= 1'b1;
        rx_min    <= bus.data_out;
        rx_max    <= bus.data_out;
      end else if (rx_active) begin
        if (bus.finish) begin
          rx_active <= 1'b0;
          rx_range  <= ((bus.data_out > rx_max) ? bus.data_out : rx_max)
                     - ((bus.data_out < rx_min) ? bus.data_out : rx_min);
        end else begin
          if (bus.data_out < rx_min) rx_min <= bus.data_out;
          if (bus.data_out > rx_max) rx_max <= bus.data_out;
        end
      end else begin
        if (bus.finish || bus.data_out != 8'h00) rx_err <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] w);
    bus.wr_data  = w;
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) break;
      tick();
    end
    chk("done_seen", bus.done, 1);
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rx_err = 1'b0; rx_active = 1'b0; rx_range = '0; rx_min = '0; rx_max = '0;
    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.send = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_go", bus.go, 0);
    chk("rst_finish", bus.finish, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_reject", bus.reject, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_range", bus.expected_range, 0);
    chk("rst_level", bus.level, 0);
    reset = 1'b0;
    tick();

    // 5,9,2,7 with send held through the sequence (ignored outside IDLE)
    load(8'd5); load(8'd9); load(8'd2); load(8'd7);
    chk("s1_level", bus.level, 4);
    chk("s1_ready", bus.wr_ready, 1);
    bus.send = 1'b1;
    tick();
    chk("s1_go", bus.go, 1);
    chk("s1_d0", bus.data_out, 5);
    chk("s1_busy", bus.busy, 1);
    chk("s1_ready_busy", bus.wr_ready, 0);
    tick();
    chk("s1_go_low", bus.go, 0);
    chk("s1_d1", bus.data_out, 9);
    chk("s1_rej_busy", bus.reject, 0);
    tick();
    chk("s1_d2", bus.data_out, 2);
    chk("s1_fin_early", bus.finish, 0);
    tick();
    chk("s1_finish", bus.finish, 1);
    chk("s1_d3", bus.data_out, 7);
    chk("s1_go_fin", bus.go, 0);
    tick();
    bus.send = 1'b0;
    chk("s1_gap_fin", bus.finish, 0);
    chk("s1_gap_data", bus.data_out, 0);
    chk("s1_gap_rej", bus.reject, 0);
    chk("s1_gap_done", bus.done, 0);
    tick();
    chk("s1_done", bus.done, 1);
    chk("s1_range", bus.expected_range, 7);
    chk("s1_rx_range", rx_range, 7);
    tick();
    chk("s1_done_pulse", bus.done, 0);
    chk("s1_idle_busy", bus.busy, 0);
    chk("s1_empty", bus.level, 0);
    chk("s1_hold_range", bus.expected_range, 7);

    // Single word: refused
    load(8'd3);
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    chk("s2_reject", bus.reject, 1);
    chk("s2_go", bus.go, 0);
    chk("s2_level", bus.level, 1);
    tick();
    chk("s2_reject_pulse", bus.reject, 0);
    chk("s2_idle", bus.busy, 0);
    // Write and send together: judged on the level before the write
    bus.wr_data = 8'd4; bus.wr_valid = 1'b1; bus.send = 1'b1;
    tick();
    bus.wr_valid = 1'b0; bus.send = 1'b0;
    chk("s2b_reject", bus.reject, 1);
    chk("s2b_level", bus.level, 2);
    chk("s2b_go", bus.go, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s2b_flush", bus.level, 0);
    chk("s2b_range_clr", bus.expected_range, 0);
    tick();

    // Full buffer of 0xFF
    for (int i = 0; i < 8; i++) load(8'hFF);
    chk("s3_level", bus.level, 8);
    chk("s3_ready", bus.wr_ready, 0);
    load(8'h00);
    chk("s3_full_drop", bus.level, 8);
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    chk("s3_go", bus.go, 1);
    chk("s3_d0", bus.data_out, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("s3_stream_go", bus.go, 0);
      chk("s3_stream_fin", bus.finish, 0);
      chk("s3_stream_d", bus.data_out, 8'hFF);
    end
    tick();
    chk("s3_finish", bus.finish, 1);
    chk("s3_dlast", bus.data_out, 8'hFF);
    tick();
    tick();
    chk("s3_done", bus.done, 1);
    chk("s3_range", bus.expected_range, 0);
    tick();
    chk("s3_empty", bus.level, 0);

    // N=2: no STREAM
    load(8'h00); load(8'hFF);
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    chk("s4_go", bus.go, 1);
    chk("s4_d0", bus.data_out, 8'h00);
    tick();
    chk("s4_finish", bus.finish, 1);
    chk("s4_d1", bus.data_out, 8'hFF);
    tick();
    chk("s4_gap", bus.done, 0);
    tick();
    chk("s4_done", bus.done, 1);
    chk("s4_range", bus.expected_range, 8'hFF);
    tick();

    // Reset in the second STREAM cycle
    load(8'd1); load(8'd2); load(8'd3); load(8'd4); load(8'd5);
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    chk("s5_go", bus.go, 1);
    tick();
    chk("s5_st1", bus.data_out, 2);
    tick();
    chk("s5_st2", bus.data_out, 3);
    reset = 1'b1;
    #1;
    chk("s5_go_low", bus.go, 0);
    chk("s5_fin_low", bus.finish, 0);
    chk("s5_busy", bus.busy, 0);
    chk("s5_level", bus.level, 0);
    chk("s5_data", bus.data_out, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s5_no_done", bus.done, 0);
      chk("s5_idle", bus.busy, 0);
    end
    chk("s5_range", bus.expected_range, 0);

    // Back-to-back sequences checked against the receiver model
    load(8'd4); load(8'd1); load(8'd6);
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    run_to_done();
    chk("s6a_range", bus.expected_range, 5);
    chk("s6a_rx", rx_range, 5);
    tick();
    load(8'd10); load(8'd10); load(8'd12);
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    run_to_done();
    chk("s6b_range", bus.expected_range, 2);
    chk("s6b_rx", rx_range, 2);
    tick();
    chk("rx_err", rx_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/range_seq_tx.md
RANGE_SEQ_TX -- requirements
Module: range_seq_tx

Interface
REQ-001 Parameter WIDTH, default 8: data word width.
REQ-002 Parameter DEPTH, default 8: maximum words per sequence; power of two, at least 2.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_valid  input  1  the producer offers wr_data for loading.
REQ-006 wr_data  input  WIDTH  word to append to the sequence buffer.
REQ-007 wr_ready  output  1  the buffer accepts a word this cycle.
REQ-008 send  input  1  start-transmission request, sampled in IDLE only.
REQ-009 busy  output  1  a sequence is in progress, from GO through DONE.
REQ-010 reject  output  1  one-cycle pulse: send was refused.
REQ-011 done  output  1  one-cycle pulse: the sequence completed and expected_range is valid.
REQ-012 go  output  1  protocol start strobe to the range receiver.
REQ-013 finish  output  1  protocol end strobe to the range receiver.
REQ-014 data_out  output  WIDTH  protocol data word.
REQ-015 expected_range  output  WIDTH  golden max minus min of the last completed sequence.
REQ-016 level  output  $clog2(DEPTH)+1  number of words in the buffer.

Function
REQ-017 wr_ready SHALL be 1 only when the state is IDLE and level < DEPTH; a word is written when wr_valid & wr_ready.
REQ-018 The FSM SHALL have the states IDLE, GO, STREAM, FINISH, GAP and DONE.
REQ-019 IDLE: go=0, finish=0, data_out=0; on send with level >= 2, latch N=level and go to GO.
REQ-020 IDLE: on send with level < 2, pulse reject the next cycle, stay in IDLE and keep the buffer contents.
REQ-021 A write and a send in the same IDLE cycle SHALL be evaluated against the level before the write.
REQ-022 GO (one cycle): go=1, finish=0, data_out=word 0; initialise min=max=word 0.
REQ-023 STREAM: go=0, finish=0, data_out=word k, for k = 1..N-2, one word per cycle; skipped when N=2.
REQ-024 FINISH (one cycle): go=0, finish=1, data_out=word N-1.
REQ-025 go and finish SHALL never be 1 in the same cycle, and go SHALL never be 1 outside GO.
REQ-026 Each emitted word SHALL update min and max with an unsigned compare; the update is registered in the cycle the word is on data_out.
REQ-027 GAP (one cycle): go=0, finish=0, data_out=0, so the receiver returns to start before any new go.
REQ-028 DONE (one cycle): done=1; expected_range = max - min, unsigned and WIDTH bits, with no wrap because max >= min.
REQ-029 DONE SHALL always be followed by IDLE, with the buffer empty (level=0).
REQ-030 Latency SHALL be: go in the cycle after send is accepted, finish N-1 cycles after go, done 2 cycles after finish.
REQ-031 send outside IDLE SHALL be ignored, with no reject pulse.
REQ-032 Equal words and an all-equal sequence SHALL give expected_range 0.
REQ-033 A sequence with N=DEPTH SHALL be sent completely; the pointer wrap inside the buffer SHALL be invisible at the outputs.
REQ-034 expected_range SHALL hold its value until the next DONE.

Reset
REQ-035 Reset SHALL put the FSM in IDLE and empty the buffer.
REQ-036 Reset SHALL clear go, finish, data_out, reject, done, busy and expected_range to 0.
REQ-037 Reset during GO, STREAM or FINISH SHALL abandon the sequence with no done pulse; go and finish fall to 0 immediately.

Structure
REQ-038 Shared package range_seq_pkg SHALL hold the state enum type and the default WIDTH and DEPTH constants.
REQ-039 One sub-module range_seq_fifo SHALL implement the buffer: synchronous write, read pointer advanced by the FSM, level count.
REQ-040 The min/max tracker and the FSM SHALL live in range_seq_tx.

Verification
REQ-041 Load 5, 9, 2, 7, then send -> go with 5; data 9, 2; finish with 7; done with expected_range=7.
REQ-042 Load a single word 3, then send -> reject pulse, no go, level stays 1.
REQ-043 Load 8 words of 0xFF (level=8, wr_ready=0), then send -> go, 6 STREAM cycles, finish; expected_range=0.
REQ-044 Load 0x00 and 0xFF, then send -> go, then finish on the next cycle, no STREAM; expected_range=0xFF.
REQ-045 Assert reset in the second STREAM cycle -> go=finish=0 immediately, no done, level=0, IDLE after reset.
REQ-046 Connect to the range receiver and run back-to-back sequences 4,1,6 then 10,10,12 -> receiver range equals expected_range (5, then 2), and its error never asserts.
